// File: rtl/uart_rx_core_if.sv
// uart_rx_core_if
//   Bundles the serial line and the received-byte outputs of uart_rx_core.
//   master : the receiver core (samples rx, drives the byte/strobe/status).
//   slave  : the line driver plus the downstream RX FIFO write wrapper.
//   Signals:
//     rx          serial line, idle high, asynchronous to clk
//     data_byte   last correctly framed byte, LSB received first
//     data_avail  one-cycle pulse, data_byte just updated
//     frame_err   one-cycle pulse, stop bit sampled low
//     busy        receiver is inside a frame (or waiting out a break)
interface uart_rx_core_if;
  logic       rx;
  logic [7:0] data_byte;
  logic       data_avail;
  logic       frame_err;
  logic       busy;

  modport master (
    input  rx,
    output data_byte,
    output data_avail,
    output frame_err,
    output busy
  );

  modport slave (
    output rx,
    input  data_byte,
    input  data_avail,
    input  frame_err,
    input  busy
  );
endinterface

// File: rtl/uart_rx_core.sv
// uart_rx_core
//   8N1 serial receive front end. Synchronises the rx pin, validates the
//   start bit at mid-bit, samples eight data bits and the stop bit at their
//   centres and presents the byte with a single-cycle strobe. A low stop bit
//   raises a single-cycle frame_err and the receiver then waits for the line
//   to return high, so a held-low break yields exactly one error.
//   Ports:
//     clk     system clock
//     rst_n   asynchronous active-low reset
//     rx_if   uart_rx_core_if.master (rx in; data_byte, data_avail,
//             frame_err, busy out)
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   S_IDLE  | line idle, waiting for rx_s low
//   S_START | counting to mid start bit, re-checking it is still low
//   S_DATA  | sampling data bits 0..7 one bit period apart
//   S_STOP  | sampling the stop bit one bit period after bit 7
//   S_BRK   | stop bit was low; waiting for the line to go high again
module uart_rx_core #(
  parameter int CLKS_PER_BIT = 868,
  parameter int SYNC_STAGES  = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_rx_core_if.master rx_if
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int HALF  = (CLKS_PER_BIT - 1) / 2;

  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(HALF);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BRK
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   rx_s;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic [7:0]       data_byte_q;
  logic             data_avail_q;
  logic             frame_err_q;
  logic             busy_q;

  // Synchroniser resets to the idle level so a reset never looks like a start bit.
  assign sync_d  = {sync_q[SYNC_STAGES-2:0], rx_if.rx};
  assign rx_s    = sync_q[SYNC_STAGES-1];
  assign cnt_inc = cnt_q + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= sync_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      data_byte_q  <= '0;
      data_avail_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      data_avail_q <= 1'b0;
      frame_err_q  <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (!rx_s) begin
            state_q <= S_START;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end

        S_START: begin
          if (cnt_q == HALF_CNT) begin
            cnt_q <= '0;
            if (!rx_s) begin
              state_q   <= S_DATA;
              bit_idx_q <= '0;
            end else begin
              // Start bit did not survive to mid-bit: treat as a glitch.
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_inc;
          end
        end

        S_DATA: begin
          if (cnt_q == LAST_CNT) begin
            cnt_q              <= '0;
            shift_q[bit_idx_q] <= rx_s;
            if (bit_idx_q == 3'd7) begin
              state_q <= S_STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_inc;
          end
        end

        S_STOP: begin
          if (cnt_q == LAST_CNT) begin
            cnt_q <= '0;
            if (rx_s) begin
              // Leaving at mid-stop-bit lets the next start edge follow immediately.
              data_byte_q  <= shift_q;
              data_avail_q <= 1'b1;
              state_q      <= S_IDLE;
              busy_q       <= 1'b0;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= S_BRK;
            end
          end else begin
            cnt_q <= cnt_inc;
          end
        end

        S_BRK: begin
          if (rx_s) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rx_if.data_byte  = data_byte_q;
  assign rx_if.data_avail = data_avail_q;
  assign rx_if.frame_err  = frame_err_q;
  assign rx_if.busy       = busy_q;

endmodule
